// File: rtl/demux_seq_pkg.sv
// Shared definitions for the demux sequencer family.
//   - 2-bit state encoding constants and the matching state enum
//   - channel (select) width
package demux_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int CHAN_W = 2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP
    } state_t;

endpackage

// File: rtl/demux_sequencer_bit_timer.sv
// bit_timer: counts clocks within one serial bit period.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : count while high
//   clr        : synchronous clear (wins over en)
//   tc         : high in the last clock of a bit period while enabled
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == LAST_CNT);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_sequencer.sv
// demux_sequencer: accepts a byte + channel over valid/ready, sets the demux
// selects while the data line is low, then shifts the byte out MSB-first,
// holding each bit for CLKS_PER_BIT clocks, followed by a one-cycle GAP with
// o_Done.
// Ports:
//   i_Clk, i_Rst_L         : clock, async active-low reset
//   i_Valid/o_Ready        : accept handshake (transfer when both high)
//   i_Chan, i_Byte         : destination channel and payload
//   o_Sel1, o_Sel0, o_Data : registered demux drive
//   o_Busy                 : high outside IDLE
//   o_Done                 : one-cycle pulse in GAP
module demux_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Valid,
    input  logic [CHAN_W-1:0]     i_Chan,
    input  logic [DATA_WIDTH-1:0] i_Byte,
    output logic                  o_Ready,
    output logic                  o_Sel1,
    output logic                  o_Sel0,
    output logic                  o_Data,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [CHAN_W-1:0]     sel_q,   sel_d;
    logic                  data_q,  data_d;
    logic                  ready_q, ready_d;
    logic                  done_q,  done_d;

    logic accept;
    logic bit_tc;

    // ready_q is low for the first cycle after reset even though the state is
    // IDLE, so it must gate the accept.
    assign accept = (state_q == IDLE) && i_Valid && ready_q;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .en    (state_q == SHIFT),
        .clr   (accept),
        .tc    (bit_tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        data_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    shift_d = i_Byte;
                    sel_d   = i_Chan;   // selects move only while data is 0
                    idx_d   = '0;
                end
            end
            SETUP: begin
                state_d = SHIFT;
                data_d  = shift_q[DATA_WIDTH-1];
            end
            SHIFT: begin
                data_d = shift_q[DATA_WIDTH-1];
                if (bit_tc) begin
                    if (idx_q == LAST_IDX) begin
                        // Last bit has had its full period: drop data, pulse done.
                        state_d = GAP;
                        data_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        shift_d = shift_q << 1;
                        idx_d   = idx_q + 1'b1;
                        data_d  = shift_d[DATA_WIDTH-1];
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            data_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign o_Ready = ready_q;
    assign o_Sel1  = sel_q[1];
    assign o_Sel0  = sel_q[0];
    assign o_Data  = data_q;
    assign o_Busy  = (state_q != IDLE);
    assign o_Done  = done_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// Scoreboard bench for demux_sequencer. Lane 0 uses the defaults
// (8 bits, 4 clocks/bit); lane 1 uses 8 bits, 1 clock/bit.
module tb_demux_sequencer;

    localparam int W = 8;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] b;
        int         acc;   // index of the accepting rising edge
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       valid   [2];
    logic [1:0] chan    [2];
    logic [7:0] byte_in [2];
    logic       ready   [2];
    logic       sel1    [2];
    logic       sel0    [2];
    logic       data    [2];
    logic       busy    [2];
    logic       done    [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    // monitor state per lane
    logic       active  [2];
    int         pos     [2];
    exp_t       cur     [2];
    logic [1:0] exp_sel [2];
    int         done_cnt[2];

    demux_sequencer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Valid(valid[0]), .i_Chan(chan[0]),
        .i_Byte(byte_in[0]), .o_Ready(ready[0]), .o_Sel1(sel1[0]),
        .o_Sel0(sel0[0]), .o_Data(data[0]), .o_Busy(busy[0]), .o_Done(done[0])
    );

    demux_sequencer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Valid(valid[1]), .i_Chan(chan[1]),
        .i_Byte(byte_in[1]), .o_Ready(ready[1]), .o_Sel1(sel1[1]),
        .o_Sel0(sel0[1]), .o_Data(data[1]), .o_Busy(busy[1]), .o_Done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input int l, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     l, name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int l);
        return (l == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int l);
        if (l == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int l, input exp_t e);
        if (l == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Monitor: follows each frame from the first busy cycle (SETUP) onward.
    always @(negedge clk) begin
        logic [1:0] sel_now;
        int         c;
        for (int l = 0; l < 2; l++) begin
            sel_now = {sel1[l], sel0[l]};
            c       = (l == 0) ? 4 : 1;
            if (!rst_n) begin
                active[l]  = 1'b0;
                exp_sel[l] = 2'b00;
            end else begin
                if (done[l]) done_cnt[l]++;
                if (!active[l]) begin
                    if (busy[l]) begin
                        check(l, "frame_expected", 32'(qsize(l) != 0), 1);
                        if (qsize(l) != 0) begin
                            cur[l]     = qpop(l);
                            active[l]  = 1'b1;
                            pos[l]     = 0;
                            exp_sel[l] = cur[l].chan;
                            check(l, "setup_cycle", cyc, cur[l].acc);
                            check(l, "setup_sel", sel_now, cur[l].chan);
                            check(l, "setup_data", data[l], 0);
                            check(l, "setup_ready", ready[l], 0);
                        end
                    end else begin
                        check(l, "idle_sel", sel_now, exp_sel[l]);
                    end
                end else begin
                    pos[l]++;
                    check(l, "frame_sel", sel_now, exp_sel[l]);
                    if (pos[l] <= W * c) begin
                        check(l, "bit", data[l], cur[l].b[W - 1 - (pos[l] - 1) / c]);
                        check(l, "shift_done", done[l], 0);
                    end else if (pos[l] == W * c + 1) begin
                        check(l, "gap_done", done[l], 1);
                        check(l, "gap_data", data[l], 0);
                        check(l, "gap_busy", busy[l], 1);
                    end else begin
                        check(l, "end_busy", busy[l], 0);
                        check(l, "end_ready", ready[l], 1);
                        check(l, "end_done", done[l], 0);
                        active[l] = 1'b0;
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int l, input logic [1:0] c, input logic [7:0] b,
                        output int acc);
        exp_t e;
        acc        = -1;
        valid[l]   = 1'b1;
        chan[l]    = c;
        byte_in[l] = b;
        for (int n = 0; n < 100; n++) begin
            if (ready[l]) begin
                acc   = cyc + 1;
                e.chan = c;
                e.b    = b;
                e.acc  = acc;
                qpush(l, e);
                break;
            end
            @(negedge clk);
        end
        check(l, "accept_in_time", 32'(acc >= 0), 1);
        @(negedge clk);
        valid[l] = 1'b0;
    endtask

    task automatic wait_idle(input int l);
        int n;
        n = 0;
        while ((busy[l] || active[l] || qsize(l) != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(l, "idle_in_time", 32'(n < 300), 1);
    endtask

    task automatic check_all_zero(input int l, input string tag);
        check(l, {tag, "_data"},  data[l],  0);
        check(l, {tag, "_sel1"},  sel1[l],  0);
        check(l, {tag, "_sel0"},  sel0[l],  0);
        check(l, {tag, "_busy"},  busy[l],  0);
        check(l, {tag, "_done"},  done[l],  0);
        check(l, {tag, "_ready"}, ready[l], 0);
    endtask

    initial begin
        int a1, a2, d0;
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            valid[l]    = 1'b0;
            chan[l]     = 2'b00;
            byte_in[l]  = 8'h00;
            done_cnt[l] = 0;
            active[l]   = 1'b0;
            exp_sel[l]  = 2'b00;
        end

        // Reset values, then o_Ready one edge after release.
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) check_all_zero(l, "reset");
        rst_n = 1'b1;
        #1;
        for (int l = 0; l < 2; l++) check(l, "ready_before_edge", ready[l], 0);
        @(negedge clk);
        for (int l = 0; l < 2; l++) check(l, "ready_after_edge", ready[l], 1);

        // Single frame 0xA5 on channel 2.
        send(0, 2'd2, 8'hA5, a1);
        wait_idle(0);
        check(0, "single_done_count", done_cnt[0], 1);

        // Back-to-back: 0xFF ch0 then 0x00 ch3 at the earliest edge.
        send(0, 2'd0, 8'hFF, a1);
        send(0, 2'd3, 8'h00, a2);
        check(0, "b2b_period", a2 - a1, 35);
        wait_idle(0);

        // Offer 0x3C while busy: must be ignored.
        d0 = done_cnt[0];
        send(0, 2'd1, 8'h12, a1);
        repeat (8) @(negedge clk);
        valid[0]   = 1'b1;
        chan[0]    = 2'd2;
        byte_in[0] = 8'h3C;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (40) @(negedge clk);
        check(0, "busy_ignore_done_count", done_cnt[0] - d0, 1);

        // Reset during bit 3 of a frame.
        d0 = done_cnt[0];
        send(0, 2'd2, 8'hC3, a1);
        while (cyc < a1 + 14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero(0, "abort");
        repeat (2) @(negedge clk);
        check(0, "abort_no_done", done_cnt[0] - d0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 2'd1, 8'h81, a1);
        wait_idle(0);
        check(0, "post_reset_done_count", done_cnt[0] - d0, 1);

        // Minimum timing on lane 1: 0x80 then 0x5A back-to-back.
        send(1, 2'd3, 8'h80, a1);
        send(1, 2'd0, 8'h5A, a2);
        check(1, "min_period", a2 - a1, 11);
        wait_idle(1);
        check(1, "min_done_count", done_cnt[1], 2);

        for (int l = 0; l < 2; l++) check(l, "queue_drained", qsize(l), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
